ghash_acc_par: RTL and testbench

Parametrised, multi-lane GHASH accumulator. Each accepted beat absorbs up to LANES 128-bit blocks into the running hash using precomputed powers of the hash key H. On the beat flagged last, the block emits the tag. It sits above the pipelined GF(2^128) multiplier (`and_xor`, 2-cycle latency) and instantiates LANES copies of it plus one shared copy for key-power generation.

---
 rtl/ghash_acc_par.sv | 232 +++++++++++++++++++++++
 tb/tb_ghash_acc_par.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ghash_acc_par.sv
// Multi-lane GHASH accumulator: absorbs up to LANES blocks per beat using precomputed powers of H.
// Latency: beat accepted at edge t updates Y at edge t+MUL_LAT; tag valid the cycle after that edge.
// Backpressure: o_ready low while keyless, generating key powers, with a beat in flight, or on key load.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_h_valid, i_h       key load pulse and 128-bit hash key H
//   i_valid, o_ready     beat handshake
//   i_data, i_cnt        LANES blocks (lane 0 = bits [127:0] = earliest), count of valid lanes
//   i_last               final beat of message
//   o_valid, o_tag       one-cycle tag pulse, tag held until next tag or reset

// Pipelined GF(2^128) multiplier, bit i = coeff of x^i, poly x^128+x^7+x^2+x+1.
// Latency: operands sampled at edge e are on p_o during the cycle ending at edge e+LAT.
// Backpressure: none, free-running pipeline.
module and_xor #(
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] a_i,
  input  logic [127:0] b_i,
  output logic [127:0] p_o
);

  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) z = z ^ v;
      v = {v[126:0], 1'b0} ^ ({128{v[127]}} & 128'h87);
    end
    return z;
  endfunction

  logic [127:0] pipe_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= gf_mul(a_i, b_i);
      for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign p_o = pipe_q[LAT-1];

endmodule

module ghash_acc_par #(
  parameter int LANES   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_h_valid,
  input  logic [127:0]               i_h,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*128-1:0]       i_data,
  input  logic [$clog2(LANES+1)-1:0] i_cnt,
  input  logic                       i_last,
  output logic                       o_valid,
  output logic [127:0]               o_tag
);

  localparam int CW = $clog2(LANES + 1);
  localparam int TW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYGEN = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_BUSY   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [127:0]  hpow_q [LANES];   // hpow_q[p] = H^(p+1)
  logic [127:0]  hpow_d [LANES];
  logic [127:0]  y_q, y_d;
  logic [127:0]  tag_q, tag_d;
  logic          vld_q, vld_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] j_q, j_d;
  logic          kz_q, kz_d;
  logic          last_q, last_d;

  logic          ready;
  logic          key_load;
  logic          accept;
  logic          stage_done;
  logic [CW-1:0] k;
  logic [127:0]  lane_a [LANES];
  logic [127:0]  lane_b [LANES];
  logic [127:0]  lane_p [LANES];
  logic [127:0]  lane_sum;
  logic [127:0]  sh_a, sh_b, sh_p;
  logic [127:0]  y_new;

  assign ready      = (state_q == S_READY) & ~i_h_valid;
  assign key_load   = i_h_valid & ((state_q == S_IDLE) | (state_q == S_READY));
  assign accept     = i_valid & ready;
  assign stage_done = (cnt_q == TW'(MUL_LAT - 1));
  assign k          = (int'(i_cnt) > LANES) ? CW'(LANES) : i_cnt;

  // Lane i multiplies by H^(k-i); Y folds into lane 0. Lanes past k contribute zero.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_a[i] = '0;
      lane_b[i] = '0;
      if (i < int'(k)) begin
        lane_a[i] = i_data[i*128 +: 128] ^ ((i == 0) ? y_q : 128'h0);
        for (int p = 0; p < LANES; p++) begin
          if (p == int'(k) - 1 - i) lane_b[i] = hpow_q[p];
        end
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum ^ lane_p[i];
  end

  // Shared multiplier: H*H on the load cycle, then the power just completing
  // is fed straight back so each step costs exactly MUL_LAT cycles.
  assign sh_a  = key_load ? i_h : sh_p;
  assign sh_b  = key_load ? i_h : hpow_q[0];
  assign y_new = kz_q ? y_q : lane_sum;

  always_comb begin
    state_d = state_q;
    hpow_d  = hpow_q;
    y_d     = y_q;
    tag_d   = tag_q;
    vld_d   = 1'b0;
    cnt_d   = cnt_q;
    j_d     = j_q;
    kz_d    = kz_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (key_load) begin
          hpow_d[0] = i_h;
          y_d       = '0;
          cnt_d     = '0;
          j_d       = CW'(1);
          state_d   = (LANES == 1) ? S_READY : S_KEYGEN;
        end else if (accept) begin
          cnt_d   = '0;
          kz_d    = (k == '0);
          last_d  = i_last;
          state_d = S_BUSY;
        end
      end
      S_KEYGEN: begin
        if (stage_done) begin
          for (int p = 1; p < LANES; p++) begin
            if (int'(j_q) == p) hpow_d[p] = sh_p;
          end
          cnt_d = '0;
          j_d   = j_q + CW'(1);
          if (int'(j_q) == LANES - 1) state_d = S_READY;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin  // S_BUSY
        if (stage_done) begin
          if (last_q) begin
            tag_d = y_new;
            vld_d = 1'b1;
            y_d   = '0;
          end else begin
            y_d = y_new;
          end
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int p = 0; p < LANES; p++) hpow_q[p] <= '0;
      y_q    <= '0;
      tag_q  <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      j_q    <= '0;
      kz_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hpow_q  <= hpow_d;
      y_q     <= y_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      kz_q    <= kz_d;
      last_q  <= last_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    and_xor #(.LAT(MUL_LAT)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a_i   (lane_a[g]),
      .b_i   (lane_b[g]),
      .p_o   (lane_p[g])
    );
  end

  and_xor #(.LAT(MUL_LAT)) u_mul_key (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (sh_a),
    .b_i   (sh_b),
    .p_o   (sh_p)
  );

  assign o_ready = ready;
  assign o_valid = vld_q;
  assign o_tag   = tag_q;

endmodule

// File: tb/tb_ghash_acc_par.sv
// Directed bench for ghash_acc_par (LANES=4, MUL_LAT=2).
// Inputs are driven 1 time unit after the rising edge, outputs sampled there too.
// Expected tags come from hand-computed constants and a bit-serial GF(2^128) reference.
module tb_ghash_acc_par;

  localparam int LANES = 4;
  localparam int ML    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_h_valid;
  logic [127:0]         i_h;
  logic                 i_valid;
  logic                 o_ready;
  logic [LANES*128-1:0] i_data;
  logic [2:0]           i_cnt;
  logic                 i_last;
  logic                 o_valid;
  logic [127:0]         o_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ghash_acc_par #(.LANES(LANES), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_h_valid (i_h_valid),
    .i_h       (i_h),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_cnt     (i_cnt),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .o_tag     (o_tag)
  );

  // Reference multiply, MSB-first Horner over the bits of b.
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z;
    z = '0;
    for (int i = 127; i >= 0; i--) begin
      z = {z[126:0], 1'b0} ^ (z[127] ? 128'h87 : 128'h0);
      if (b[i]) z = z ^ a;
    end
    return z;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Load key from a post-edge point; checks o_ready over the key generation window.
  task automatic load_key(input logic [127:0] h);
    i_h_valid = 1'b1;
    i_h       = h;
    step();
    i_h_valid = 1'b0;
    for (int n = 0; n <= (LANES-1)*ML; n++) begin
      if (n > 0) step();
      chk($sformatf("keygen_ready_%0d", n), {127'b0, o_ready}, {127'b0, (n == (LANES-1)*ML)});
    end
  endtask

  // Present a beat and wait (bounded) for its accept edge; returns at accept edge + 1.
  task automatic send(input logic [LANES*128-1:0] d, input logic [2:0] c, input logic l, input logic hold);
    int n;
    i_valid = 1'b1;
    i_data  = d;
    i_cnt   = c;
    i_last  = l;
    n = 0;
    while (!o_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_ready", {127'b0, o_ready}, 128'd1);
    step();
    if (!hold) i_valid = 1'b0;
  endtask

  // From accept edge + 1: o_valid must pulse only in the cycle after accept + MUL_LAT.
  task automatic expect_tag(input string tag, input logic [127:0] exp);
    for (int n = 0; n <= ML + 1; n++) begin
      if (n > 0) step();
      chk($sformatf("%s_vld%0d", tag, n), {127'b0, o_valid}, {127'b0, (n == ML)});
      if (n == ML) chk({tag, "_tag"}, o_tag, exp);
    end
  endtask

  logic [127:0] hr;
  logic [127:0] xb [4];
  logic [127:0] yref;

  initial begin
    rst_n     = 1'b0;
    i_h_valid = 1'b0;
    i_h       = '0;
    i_valid   = 1'b0;
    i_data    = '0;
    i_cnt     = '0;
    i_last    = 1'b0;

    // 1: reset state, then key load timing
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {127'b0, o_ready}, 128'd0);
    chk("rst_valid", {127'b0, o_valid}, 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", {127'b0, o_ready}, 128'd0);
    load_key(128'h2);

    // 2: x * x = x^2
    send({384'b0, 128'h2}, 3'd1, 1'b1, 1'b0);
    expect_tag("t2", 128'h4);

    // 3: x^127 * x reduces to 0x87
    send({384'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000}, 3'd1, 1'b1, 1'b0);
    expect_tag("t3", 128'h87);

    // 4: two lanes, upper lanes all-ones must be ignored: x^2 + x
    send({{256{1'b1}}, 128'h1, 128'h1}, 3'd2, 1'b1, 1'b0);
    expect_tag("t4", 128'h6);

    // 5: back-to-back beats with i_valid held high
    send({384'b0, 128'h1}, 3'd1, 1'b0, 1'b1);
    i_data = {384'b0, 128'h0};
    i_last = 1'b1;
    chk("t5_busy0", {127'b0, o_ready}, 128'd0);
    step();
    chk("t5_busy1", {127'b0, o_ready}, 128'd0);
    step();
    chk("t5_ready", {127'b0, o_ready}, 128'd1);
    step();
    i_valid = 1'b0;
    expect_tag("t5", 128'h4);
    send({384'b0, 128'h1}, 3'd1, 1'b1, 1'b0);
    expect_tag("t5_clear", 128'h2);

    // 6a: random key, one 4-lane beat vs four 1-lane beats vs clamped count
    hr = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 4; i++) xb[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    yref = '0;
    for (int i = 0; i < 4; i++) yref = gmul(yref ^ xb[i], hr);
    load_key(hr);
    send({xb[3], xb[2], xb[1], xb[0]}, 3'd4, 1'b1, 1'b0);
    expect_tag("eq_wide", yref);
    for (int i = 0; i < 3; i++) send({384'b0, xb[i]}, 3'd1, 1'b0, 1'b0);
    send({384'b0, xb[3]}, 3'd1, 1'b1, 1'b0);
    expect_tag("eq_split", yref);
    send({xb[3], xb[2], xb[1], xb[0]}, 3'd7, 1'b1, 1'b0);
    expect_tag("eq_clamp", yref);

    // 6b: a zero-lane beat leaves Y untouched
    send({512{1'b1}}, 3'd0, 1'b0, 1'b0);
    send({384'b0, 128'h1}, 3'd1, 1'b1, 1'b0);
    expect_tag("k0", hr);

    // 6c: reset mid-flight
    send({384'b0, 128'h5}, 3'd1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {127'b0, o_ready}, 128'd0);
    chk("mid_rst_valid", {127'b0, o_valid}, 128'd0);
    chk("mid_rst_tag", o_tag, 128'd0);
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("post_rst_valid%0d", n), {127'b0, o_valid}, 128'd0);
      chk($sformatf("post_rst_ready%0d", n), {127'b0, o_ready}, 128'd0);
    end
    load_key(128'h2);
    send({384'b0, 128'h2}, 3'd1, 1'b1, 1'b0);
    expect_tag("post_rst", 128'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
